seg_anim_sequencer: RTL and testbench



---
 rtl/seg_anim_sequencer.sv | 177 +++++++++++++++++
 tb/tb_seg_anim_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_anim_sequencer.sv
// Seven-segment animation scheduler: frame-tick prescaler, IDLE/SWITCH/PLAY sequencing
// with hold/skip/enable control, and the animation-select/frame outputs.
// Optional build macro SEQ_SHUFFLE_EN selects a pseudo-random next animation from an
// 8-bit LFSR; when undefined, animations advance strictly in order.
module seg_anim_sequencer #(
   parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
   parameter int unsigned NUM_ANIM  = 6,
   parameter int unsigned REPEAT    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] speed_in,
   input  logic       hold,
   input  logic       skip,
   output logic [2:0] anim_sel,
   output logic [3:0] frame,
   output logic       blank,
   output logic       tick,
   output logic       anim_start
);

   typedef enum logic [1:0] {StIdle, StSwitch, StPlay} state_e;

   localparam logic [2:0] LastIdx  = 3'(NUM_ANIM - 1);
   localparam logic [3:0] LastLoop = 4'(REPEAT - 1);

   state_e      state_q, state_d;
   logic [23:0] presc_q, presc_d;
   logic [3:0]  frame_q, frame_d;
   logic [2:0]  sel_q, sel_d;
   logic [2:0]  target_q, target_d;   // animation loaded when SWITCH hands over to PLAY
   logic [3:0]  loop_q, loop_d;
   logic        start_q, start_d;

   logic [23:0] compare;
   logic [3:0]  last_frame;
   logic [2:0]  seq_next, next_idx;
   logic        wrap, at_last, last_loop, anim_done;

   assign compare   = (speed_in == 8'd0) ? MAX_COUNT : {6'b0, speed_in, 10'b0};
   // >= rather than == so that lowering the compare below the count ticks at once
   assign wrap      = (state_q == StPlay) && (presc_q >= compare);
   assign at_last   = (frame_q == last_frame);
   assign last_loop = (loop_q == LastLoop);
   assign anim_done = wrap && at_last && last_loop && !hold;
   assign seq_next  = (sel_q == LastIdx) ? 3'd0 : sel_q + 3'd1;

   // Last frame of each animation
   always_comb begin
      unique case (sel_q)
         3'd0:                last_frame = 4'd9;
         3'd1, 3'd2, 3'd3:    last_frame = 4'd6;
         default:             last_frame = 4'd5;
      endcase
   end

`ifdef SEQ_SHUFFLE_EN
   localparam logic [2:0] NumAnimW = 3'(NUM_ANIM);

   logic [7:0] lfsr_q;
   logic [2:0] rnd_raw, rnd;

   // Free-running Fibonacci LFSR, taps 8,6,5,4
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= 8'hA5;
      else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   // Fold the random pick into range and never repeat the current animation
   always_comb begin
      rnd_raw  = lfsr_q[2:0];
      rnd      = (32'(rnd_raw) >= NUM_ANIM) ? rnd_raw - NumAnimW : rnd_raw;
      next_idx = (rnd == sel_q) ? seq_next : rnd;
   end
`else
   assign next_idx = seq_next;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state: enable beats skip beats tick
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (enable) state_d = StSwitch;
         StSwitch: state_d = enable ? StPlay : StIdle;
         StPlay: begin
            if (!enable)                 state_d = StIdle;
            else if (skip || anim_done)  state_d = StSwitch;
         end
         default:  state_d = StIdle;
      endcase
   end

   // Datapath next-state: prescaler, frame, loop counter and animation index
   always_comb begin
      presc_d  = presc_q;
      frame_d  = frame_q;
      sel_d    = sel_q;
      loop_d   = loop_q;
      target_d = target_q;
      unique case (state_q)
         StIdle: begin
            presc_d  = '0;
            frame_d  = '0;
            sel_d    = '0;
            loop_d   = '0;
            target_d = '0;   // leaving IDLE always starts from animation 0
         end
         StSwitch: begin
            sel_d   = target_q;
            frame_d = '0;
            loop_d  = '0;
            presc_d = '0;
         end
         StPlay: begin
            if (skip) begin
               target_d = next_idx;   // a coincident tick is dropped
            end else if (wrap) begin
               presc_d = '0;
               if (at_last) begin
                  frame_d = '0;
                  if (!last_loop) loop_d = loop_q + 4'd1;
                  if (anim_done)  target_d = next_idx;
               end else begin
                  frame_d = frame_q + 4'd1;
               end
            end else begin
               presc_d = presc_q + 24'd1;
            end
         end
         default: ;
      endcase
      if (!enable) begin
         presc_d = '0;
         frame_d = '0;
         sel_d   = '0;
         loop_d  = '0;
      end
   end

   assign start_d = (state_q == StSwitch) && enable;

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q  <= '0;
         frame_q  <= '0;
         sel_q    <= '0;
         target_q <= '0;
         loop_q   <= '0;
         start_q  <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         frame_q  <= frame_d;
         sel_q    <= sel_d;
         target_q <= target_d;
         loop_q   <= loop_d;
         start_q  <= start_d;
      end
   end

   // Outputs
   always_comb begin
      anim_sel   = sel_q;
      frame      = frame_q;
      blank      = (state_q != StPlay);
      tick       = wrap;
      anim_start = start_q;
   end

endmodule

// File: tb/tb_seg_anim_sequencer.sv
// Self-checking bench for seg_anim_sequencer: directed vector table, hand sequences for
// hold/skip/speed/enable/reset corners, then random stimulus against a reference model.
module tb_seg_anim_sequencer;

   localparam logic [23:0] MaxCount = 24'd4;
   localparam int NumAnim = 6;
   localparam int Repeat  = 1;
   localparam int MIdle = 0, MSwitch = 1, MPlay = 2;

   logic       clk = 1'b0;
   logic       reset, enable, hold, skip;
   logic [7:0] speed_in;
   logic [2:0] anim_sel;
   logic [3:0] frame;
   logic       blank, tick, anim_start;

   seg_anim_sequencer #(
      .MAX_COUNT (MaxCount),
      .NUM_ANIM  (NumAnim),
      .REPEAT    (Repeat)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .speed_in   (speed_in),
      .hold       (hold),
      .skip       (skip),
      .anim_sel   (anim_sel),
      .frame      (frame),
      .blank      (blank),
      .tick       (tick),
      .anim_start (anim_start)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int last_tbl [8] = '{9, 6, 6, 6, 5, 5, 5, 5};

   // Reference model state
   int m_mode, m_sel, m_frame, m_loops, m_pending, m_count;
   bit m_start;

   // Last observed DUT outputs
   int obs_sel, obs_frame;
   bit obs_blank, obs_tick, obs_start;

   typedef struct {
      bit en;
      bit sk;
      int blank;
      int sel;     // -1: not compared (display blanked in SWITCH)
      int frame;
      int start;
      int tick;
   } vec_t;
   vec_t tbl [19];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int cmp_of(input logic [7:0] s);
      return (s == 8'd0) ? int'(MaxCount) : int'(s) * 1024;
   endfunction

   function automatic bit model_tick();
      return (m_mode == MPlay) && (m_count >= cmp_of(speed_in));
   endfunction

   task automatic model_reset();
      m_mode = MIdle; m_sel = 0; m_frame = 0; m_loops = 0; m_pending = 0; m_count = 0;
      m_start = 0;
   endtask

   // Advance the model by one clock using the inputs currently applied
   task automatic model_step();
      bit t;
      bit ns;
      t  = model_tick();
      ns = (m_mode == MSwitch) && enable;
      if (!enable) begin
         m_mode = MIdle; m_sel = 0; m_frame = 0; m_count = 0; m_loops = 0;
      end else begin
         case (m_mode)
            MIdle: begin
               m_mode = MSwitch; m_pending = 0;
            end
            MSwitch: begin
               m_mode = MPlay; m_sel = m_pending; m_frame = 0; m_loops = 0; m_count = 0;
            end
            default: begin
               if (skip) begin
                  m_mode = MSwitch; m_pending = (m_sel + 1) % NumAnim;
               end else if (t) begin
                  m_count = 0;
                  if (m_frame == last_tbl[m_sel]) begin
                     m_frame = 0;
                     if (m_loops + 1 < Repeat) m_loops++;
                     else if (!hold) begin
                        m_mode = MSwitch; m_pending = (m_sel + 1) % NumAnim;
                     end
                  end else begin
                     m_frame++;
                  end
               end else begin
                  m_count++;
               end
            end
         endcase
      end
      m_start = ns;
   endtask

   task automatic observe();
      obs_sel = int'(anim_sel); obs_frame = int'(frame);
      obs_blank = blank; obs_tick = tick; obs_start = anim_start;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".blank"}, int'(blank), (m_mode != MPlay) ? 1 : 0);
      check({tag, ".tick"}, int'(tick), int'(model_tick()));
      check({tag, ".start"}, int'(anim_start), int'(m_start));
      if (m_mode != MSwitch) begin
         check({tag, ".sel"}, int'(anim_sel), m_sel);
         check({tag, ".frame"}, int'(frame), m_frame);
      end
   endtask

   // One clock: compare on the falling edge, step model on the rising edge
   task automatic cycle(input string tag);
      @(negedge clk);
      observe();
      check_model(tag);
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      n_bad++;
      summary();
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int cnt;
      int saved;
      bit found;

      tbl[0]  = '{0, 0, 1,  0,  0, 0, 0};
      tbl[1]  = '{1, 0, 1,  0,  0, 0, 0};
      tbl[2]  = '{1, 0, 1, -1, -1, 0, 0};
      tbl[3]  = '{1, 0, 0,  0,  0, 1, 0};
      tbl[4]  = '{1, 0, 0,  0,  0, 0, 0};
      tbl[5]  = '{1, 0, 0,  0,  0, 0, 0};
      tbl[6]  = '{1, 0, 0,  0,  0, 0, 0};
      tbl[7]  = '{1, 0, 0,  0,  0, 0, 1};
      tbl[8]  = '{1, 0, 0,  0,  1, 0, 0};
      tbl[9]  = '{1, 0, 0,  0,  1, 0, 0};
      tbl[10] = '{1, 0, 0,  0,  1, 0, 0};
      tbl[11] = '{1, 0, 0,  0,  1, 0, 0};
      tbl[12] = '{1, 0, 0,  0,  1, 0, 1};
      tbl[13] = '{1, 1, 0,  0,  2, 0, 0};
      tbl[14] = '{1, 0, 1, -1, -1, 0, 0};
      tbl[15] = '{1, 0, 0,  1,  0, 1, 0};
      tbl[16] = '{0, 0, 0,  1,  0, 0, 0};
      tbl[17] = '{0, 0, 1,  0,  0, 0, 0};
      tbl[18] = '{0, 1, 1,  0,  0, 0, 0};

      reset = 1'b1; enable = 1'b0; hold = 1'b0; skip = 1'b0; speed_in = 8'd0;
      #12;
      check("rst.blank", int'(blank), 1);
      check("rst.sel", int'(anim_sel), 0);
      check("rst.frame", int'(frame), 0);
      check("rst.tick", int'(tick), 0);
      check("rst.start", int'(anim_start), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();

      // Directed vectors from reset
      for (int i = 0; i < 19; i++) begin
         enable = tbl[i].en; skip = tbl[i].sk;
         @(negedge clk);
         check($sformatf("vec%0d.blank", i), int'(blank), tbl[i].blank);
         if (tbl[i].sel >= 0) check($sformatf("vec%0d.sel", i), int'(anim_sel), tbl[i].sel);
         if (tbl[i].frame >= 0) check($sformatf("vec%0d.frame", i), int'(frame), tbl[i].frame);
         check($sformatf("vec%0d.start", i), int'(anim_start), tbl[i].start);
         check($sformatf("vec%0d.tick", i), int'(tick), tbl[i].tick);
         @(posedge clk);
         model_step();
         #1;
      end
      skip = 1'b0;

      // Full pass through every animation, starting from IDLE
      enable = 1'b1;
      k = 0;
      for (int c = 0; c < 400 && k < 7; c++) begin
         cycle("seq");
         if (obs_start) begin
            check("seq.order", obs_sel, k % NumAnim);
            k++;
         end
      end
      if (k < 7) check("seq.timeout", k, 7);

      // Hold during animation 2: keeps looping, release advances to 3
      found = 0;
      for (int c = 0; c < 400 && !found; c++) begin
         cycle("to2");
         found = obs_start && (obs_sel == 2);
      end
      if (!found) check("to2.timeout", 0, 1);
      hold = 1'b1;
      cnt = 0;
      for (int c = 0; c < 120; c++) begin
         cycle("hold");
         if (obs_blank) cnt++;
      end
      check("hold.noswitch", cnt, 0);
      check("hold.sel", obs_sel, 2);
      hold = 1'b0;
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         cycle("unhold");
         found = obs_start;
      end
      if (!found) check("unhold.timeout", 0, 1);
      check("unhold.sel", obs_sel, 3);

      // Skip coincident with a tick at frame 3
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         if (m_mode == MPlay && m_frame == 3 && model_tick()) found = 1;
         else cycle("toskip");
      end
      if (!found) check("toskip.timeout", 0, 1);
      saved = m_sel;
      skip = 1'b1;
      cycle("skip");
      check("skip.frame", obs_frame, 3);
      check("skip.tick", int'(obs_tick), 1);
      skip = 1'b0;
      cycle("skip1");
      check("skip1.blank", int'(obs_blank), 1);
      cycle("skip2");
      check("skip2.sel", obs_sel, (saved + 1) % NumAnim);
      check("skip2.frame", obs_frame, 0);
      check("skip2.start", int'(obs_start), 1);

      // Lowering the compare below the running count ticks at once
      speed_in = 8'h08;
      found = 0;
      for (int c = 0; c < 6000 && !found; c++) begin
         if (m_count == 5000) found = 1;
         else cycle("spdup");
      end
      if (!found) check("spdup.timeout", 0, 1);
      speed_in = 8'h01;
      cycle("spd");
      check("spd.tick", int'(obs_tick), 1);
      cnt = 0;
      found = 0;
      for (int c = 0; c < 1100 && !found; c++) begin
         cycle("spdper");
         cnt++;
         found = obs_tick;
      end
      check("spd.period", cnt, 1025);
      speed_in = 8'd0;

      // enable low mid-animation
      enable = 1'b0;
      cycle("dis0");
      cycle("dis1");
      check("dis.blank", int'(obs_blank), 1);
      check("dis.sel", obs_sel, 0);
      check("dis.frame", obs_frame, 0);
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         cycle("idle");
         if (obs_tick) cnt++;
      end
      check("idle.ticks", cnt, 0);

      // Asynchronous reset during PLAY
      enable = 1'b1;
      for (int c = 0; c < 12; c++) cycle("prerst");
      #1;
      reset = 1'b1;
      #1;
      check("arst.blank", int'(blank), 1);
      check("arst.sel", int'(anim_sel), 0);
      check("arst.frame", int'(frame), 0);
      check("arst.tick", int'(tick), 0);
      check("arst.start", int'(anim_start), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();

      // Random stimulus against the model
      for (int c = 0; c < 4000; c++) begin
         enable = ($urandom_range(0, 99) != 0);
         skip = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 29) == 0) hold = ~hold;
         speed_in = ($urandom_range(0, 31) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
         cycle("rnd");
      end

      summary();
      $finish;
   end

endmodule
